// File: rtl/spi_reg_ctrl.sv
// SPI slave front end: oversamples sclk/csb/sdi on clk and turns the 16-bit
// instruction + data byte protocol into register-file write strobes and reads.
//   state   | meaning
//   IDLE    | waiting for csb falling edge
//   INSTR   | shifting in the 16-bit instruction word
//   WR_DATA | shifting in write bytes, one write strobe per byte
//   RD_DATA | shifting out read bytes on sdo, prefetching the next byte
//   DONE    | all bytes transferred, waiting for csb high
module spi_reg_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int RD_LAT      = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sclk,
    input  logic        csb,
    input  logic        sdi,
    output logic        sdo,
    output logic        sdo_oe,
    output logic        write,
    output logic [12:0] Addr,
    output logic [7:0]  wrData,
    input  logic [7:0]  rdData,
    output logic        busy
);

    typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_DATA, DONE} state_t;

    localparam int PFW = $clog2(RD_LAT + 2);
    localparam logic [PFW-1:0] PF_LOAD = PFW'(RD_LAT + 1);
    localparam logic [PFW-1:0] PF_TC   = PFW'(1);

    logic [SYNC_STAGES-1:0] sclk_sync_q, csb_sync_q, sdi_sync_q, fill_q;
    logic sclk_prev_q, csb_prev_q;
    logic sclk_s, csb_s, sdi_s;
    logic sclk_rise, sclk_fall, csb_fall;

    state_t      state_q, state_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [1:0]  byte_cnt_q, byte_cnt_d;
    logic [1:0]  wlen_q, wlen_d;
    logic [15:0] in_sh_q, in_sh_d;
    logic [7:0]  rd_sh_q, rd_sh_d;
    logic [7:0]  hold_q, hold_d;
    logic        loaded_q, loaded_d;
    logic        skip_q, skip_d;
    logic [PFW-1:0] pf_cnt_q, pf_cnt_d;
    logic [12:0] addr_q, addr_d;
    logic [7:0]  wrdata_q, wrdata_d;
    logic        write_q, write_d;
    logic        sdo_oe_q, sdo_oe_d;
    logic [15:0] instr_word;
    logic        last_byte;

    assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
    assign csb_s     = csb_sync_q[SYNC_STAGES-1];
    assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
    assign sclk_rise = sclk_s & ~sclk_prev_q;
    assign sclk_fall = ~sclk_s & sclk_prev_q;
    assign csb_fall  = csb_prev_q & ~csb_s;

    // csb edges are only trusted once the synchronizer holds real pin values,
    // so a transaction already in flight across reset is never picked up.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sclk_sync_q <= '0;
            csb_sync_q  <= '1;
            sdi_sync_q  <= '0;
            fill_q      <= '0;
            sclk_prev_q <= 1'b0;
            csb_prev_q  <= 1'b0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], sclk};
            csb_sync_q  <= {csb_sync_q[SYNC_STAGES-2:0], csb};
            sdi_sync_q  <= {sdi_sync_q[SYNC_STAGES-2:0], sdi};
            fill_q      <= {fill_q[SYNC_STAGES-2:0], 1'b1};
            sclk_prev_q <= sclk_s;
            csb_prev_q  <= fill_q[SYNC_STAGES-1] & csb_s;
        end
    end

    assign instr_word = {in_sh_q[14:0], sdi_s};
    assign last_byte  = (wlen_q != 2'd3) && (byte_cnt_q == wlen_q);

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        wlen_d     = wlen_q;
        in_sh_d    = in_sh_q;
        rd_sh_d    = rd_sh_q;
        hold_d     = hold_q;
        loaded_d   = loaded_q;
        skip_d     = skip_q;
        pf_cnt_d   = pf_cnt_q;
        addr_d     = addr_q;
        wrdata_d   = wrdata_q;
        write_d    = 1'b0;
        sdo_oe_d   = sdo_oe_q;

        if (write_q)
            addr_d = addr_q - 13'd1;
        if (pf_cnt_q != '0)
            pf_cnt_d = pf_cnt_q - 1'b1;

        case (state_q)
            IDLE: begin
                bit_cnt_d  = 4'd0;
                byte_cnt_d = 2'd0;
                loaded_d   = 1'b0;
                pf_cnt_d   = '0;
                sdo_oe_d   = 1'b0;
                if (csb_fall)
                    state_d = INSTR;
            end
            INSTR: begin
                if (sclk_rise) begin
                    in_sh_d   = instr_word;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd15) begin
                        bit_cnt_d = 4'd0;
                        addr_d    = instr_word[12:0];
                        wlen_d    = instr_word[14:13];
                        if (instr_word[15]) begin
                            state_d  = RD_DATA;
                            pf_cnt_d = PF_LOAD;
                            loaded_d = 1'b0;
                            skip_d   = 1'b1;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
            end
            WR_DATA: begin
                if (sclk_rise) begin
                    in_sh_d   = instr_word;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q == 4'd7) begin
                        bit_cnt_d = 4'd0;
                        write_d   = 1'b1;
                        wrdata_d  = instr_word[7:0];
                        if (last_byte)
                            state_d = DONE;
                        else
                            byte_cnt_d = byte_cnt_q + 2'd1;
                    end
                end
            end
            RD_DATA: begin
                if (pf_cnt_q == PF_TC) begin
                    if (!loaded_q) begin
                        rd_sh_d  = rdData;
                        loaded_d = 1'b1;
                        sdo_oe_d = 1'b1;
                        addr_d   = addr_q - 13'd1;
                        pf_cnt_d = PF_LOAD;
                    end else begin
                        hold_d = rdData;
                    end
                end
                // The fall closing the instruction phase must not shift out bit 7.
                if (sclk_fall) begin
                    if (skip_q) begin
                        skip_d = 1'b0;
                    end else if (loaded_q) begin
                        rd_sh_d   = {rd_sh_q[6:0], 1'b0};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            bit_cnt_d = 4'd0;
                            if (last_byte) begin
                                state_d  = DONE;
                                sdo_oe_d = 1'b0;
                            end else begin
                                rd_sh_d    = hold_q;
                                byte_cnt_d = byte_cnt_q + 2'd1;
                                addr_d     = addr_q - 13'd1;
                                pf_cnt_d   = PF_LOAD;
                            end
                        end
                    end
                end
            end
            DONE: begin
                sdo_oe_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && csb_s) begin
            state_d  = IDLE;
            write_d  = 1'b0;
            wrdata_d = wrdata_q;
            sdo_oe_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 4'd0;
            byte_cnt_q <= 2'd0;
            wlen_q     <= 2'd0;
            in_sh_q    <= 16'd0;
            rd_sh_q    <= 8'd0;
            hold_q     <= 8'd0;
            loaded_q   <= 1'b0;
            skip_q     <= 1'b0;
            pf_cnt_q   <= '0;
            addr_q     <= 13'd0;
            wrdata_q   <= 8'd0;
            write_q    <= 1'b0;
            sdo_oe_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            byte_cnt_q <= byte_cnt_d;
            wlen_q     <= wlen_d;
            in_sh_q    <= in_sh_d;
            rd_sh_q    <= rd_sh_d;
            hold_q     <= hold_d;
            loaded_q   <= loaded_d;
            skip_q     <= skip_d;
            pf_cnt_q   <= pf_cnt_d;
            addr_q     <= addr_d;
            wrdata_q   <= wrdata_d;
            write_q    <= write_d;
            sdo_oe_q   <= sdo_oe_d;
        end
    end

    assign sdo    = rd_sh_q[7];
    assign sdo_oe = sdo_oe_q;
    assign write  = write_q;
    assign Addr   = addr_q;
    assign wrData = wrdata_q;
    assign busy   = ~csb_s;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: table of write transactions plus
// hand-written read, abort, reset and csb/byte-complete race sequences.
module tb_spi_reg_ctrl;

    logic        clk = 1'b0;
    logic        reset, sclk, csb, sdi;
    logic        sdo, sdo_oe, write, busy;
    logic [12:0] Addr;
    logic [7:0]  wrData;
    logic [7:0]  rdData;

    int tests = 0;
    int fails = 0;

    logic [20:0] wq[$];

    typedef struct {
        logic [15:0]       instr;
        logic [31:0]       data;
        int                nbits;
        int                exp_n;
        logic [3:0][20:0]  exp;
        logic [12:0]       addr_end;
    } wvec_t;

    wvec_t vecs[6];

    spi_reg_ctrl #(.SYNC_STAGES(2), .RD_LAT(1)) dut (
        .clk(clk), .reset(reset), .sclk(sclk), .csb(csb), .sdi(sdi),
        .sdo(sdo), .sdo_oe(sdo_oe), .write(write), .Addr(Addr),
        .wrData(wrData), .rdData(rdData), .busy(busy)
    );

    always #5 clk = ~clk;

    // Register-file model: returns address LSBs one clk after Addr.
    always @(posedge clk) rdData <= Addr[7:0];

    always @(negedge clk) if (write === 1'b1) wq.push_back({Addr, wrData});

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic spi_bit(input logic b, output logic so);
        sdi = b;
        #50;
        so = sdo;
        sclk = 1'b1;
        #50;
        sclk = 1'b0;
    endtask

    task automatic spi_xfer(input logic [15:0] instr, input logic [31:0] data, input int nbits);
        logic so;
        @(negedge clk);
        csb = 1'b0;
        #50;
        for (int i = 0; i < 16; i++) spi_bit(instr[15-i], so);
        for (int i = 0; i < nbits; i++) spi_bit(data[31-i], so);
        #50;
        csb = 1'b1;
        #100;
    endtask

    initial begin
        logic so;
        logic [7:0] rb;
        logic [7:0] rd_exp [3];

        vecs[0] = '{instr: 16'h0005, data: 32'h3C00_0000, nbits: 8, exp_n: 1,
                    exp: {21'h0, 21'h0, 21'h0, {13'h0005, 8'h3C}}, addr_end: 13'h0004};
        vecs[1] = '{instr: 16'h4014, data: 32'hA1B2_C3D4, nbits: 32, exp_n: 3,
                    exp: {21'h0, {13'h0012, 8'hC3}, {13'h0013, 8'hB2}, {13'h0014, 8'hA1}},
                    addr_end: 13'h0011};
        vecs[2] = '{instr: 16'h0010, data: 32'hA800_0000, nbits: 5, exp_n: 0,
                    exp: {21'h0, 21'h0, 21'h0, 21'h0}, addr_end: 13'h0010};
        vecs[3] = '{instr: 16'h0011, data: 32'h5500_0000, nbits: 8, exp_n: 1,
                    exp: {21'h0, 21'h0, 21'h0, {13'h0011, 8'h55}}, addr_end: 13'h0010};
        vecs[4] = '{instr: 16'h2000, data: 32'h1234_0000, nbits: 16, exp_n: 2,
                    exp: {21'h0, 21'h0, {13'h1FFF, 8'h34}, {13'h0000, 8'h12}}, addr_end: 13'h1FFE};
        vecs[5] = '{instr: 16'h6100, data: 32'h1122_3344, nbits: 32, exp_n: 4,
                    exp: {{13'h00FD, 8'h44}, {13'h00FE, 8'h33}, {13'h00FF, 8'h22}, {13'h0100, 8'h11}},
                    addr_end: 13'h00FC};

        reset = 1'b1; sclk = 1'b0; csb = 1'b1; sdi = 1'b0;
        #37;
        check("rst_sdo", 32'(sdo), 32'h0);
        check("rst_sdo_oe", 32'(sdo_oe), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_addr", 32'(Addr), 32'h0);
        check("rst_wrdata", 32'(wrData), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        #100;

        for (int i = 0; i < 6; i++) begin
            wq.delete();
            spi_xfer(vecs[i].instr, vecs[i].data, vecs[i].nbits);
            check($sformatf("v%0d_nwrites", i), 32'(wq.size()), 32'(vecs[i].exp_n));
            for (int k = 0; k < vecs[i].exp_n; k++)
                check($sformatf("v%0d_wr%0d", i, k),
                      (k < wq.size()) ? 32'(wq[k]) : 32'hFFFF_FFFF, 32'(vecs[i].exp[k]));
            check($sformatf("v%0d_addr_end", i), 32'(Addr), 32'(vecs[i].addr_end));
            check($sformatf("v%0d_busy_idle", i), 32'(busy), 32'h0);
        end

        // Streaming read with address wrap.
        wq.delete();
        rd_exp[0] = 8'h01; rd_exp[1] = 8'h00; rd_exp[2] = 8'hFF;
        @(negedge clk);
        csb = 1'b0;
        #50;
        for (int i = 0; i < 16; i++) begin
            rb = 8'hE0 >> 0;
            spi_bit((i < 3) ? 1'b1 : (i == 15), so);
        end
        #40;
        check("rd_oe_after_load", 32'(sdo_oe), 32'h1);
        check("rd_addr_after_load", 32'(Addr), 32'h0);
        check("rd_busy", 32'(busy), 32'h1);
        for (int j = 0; j < 3; j++) begin
            rb = 8'h00;
            for (int b = 0; b < 8; b++) begin
                spi_bit(1'b0, so);
                rb = {rb[6:0], so};
            end
            check($sformatf("rd_stream_byte%0d", j), 32'(rb), 32'(rd_exp[j]));
        end
        check("rd_stream_oe_hold", 32'(sdo_oe), 32'h1);
        #50;
        csb = 1'b1;
        #40;
        check("rd_oe_csb_rise", 32'(sdo_oe), 32'h0);
        check("rd_busy_csb_rise", 32'(busy), 32'h0);
        check("rd_no_write", 32'(wq.size()), 32'h0);
        #60;

        // Two-byte read: sdo_oe drops after N bytes while csb is still low.
        rd_exp[0] = 8'h05; rd_exp[1] = 8'h04;
        @(negedge clk);
        csb = 1'b0;
        #50;
        for (int i = 0; i < 16; i++) spi_bit(((16'hA005 >> (15 - i)) & 16'h1) != 16'h0, so);
        for (int j = 0; j < 2; j++) begin
            rb = 8'h00;
            for (int b = 0; b < 8; b++) begin
                spi_bit(1'b0, so);
                rb = {rb[6:0], so};
            end
            check($sformatf("rd2_byte%0d", j), 32'(rb), 32'(rd_exp[j]));
        end
        #50;
        check("rd2_oe_done", 32'(sdo_oe), 32'h0);
        check("rd2_busy_done", 32'(busy), 32'h1);
        check("rd2_addr_done", 32'(Addr), 32'h0003);
        csb = 1'b1;
        #100;

        // Reset during the second byte of a streaming read.
        @(negedge clk);
        csb = 1'b0;
        #50;
        for (int i = 0; i < 16; i++) spi_bit(((16'hE003 >> (15 - i)) & 16'h1) != 16'h0, so);
        for (int i = 0; i < 11; i++) spi_bit(1'b0, so);
        reset = 1'b1;
        #1;
        check("mid_rst_oe", 32'(sdo_oe), 32'h0);
        check("mid_rst_addr", 32'(Addr), 32'h0);
        check("mid_rst_sdo", 32'(sdo), 32'h0);
        #19;
        reset = 1'b0;
        wq.delete();
        for (int i = 0; i < 8; i++) spi_bit(1'b1, so);
        check("post_rst_no_resume_oe", 32'(sdo_oe), 32'h0);
        check("post_rst_no_write", 32'(wq.size()), 32'h0);
        #50;
        csb = 1'b1;
        #100;
        spi_xfer(16'h0007, 32'h9A00_0000, 8);
        check("post_rst_wr_n", 32'(wq.size()), 32'h1);
        check("post_rst_wr", (wq.size() > 0) ? 32'(wq[0]) : 32'hFFFF_FFFF, 32'({13'h0007, 8'h9A}));

        // csb rises in the same synchronized clk as the 8th data rise.
        wq.delete();
        @(negedge clk);
        csb = 1'b0;
        #50;
        for (int i = 0; i < 16; i++) spi_bit(((16'h0020 >> (15 - i)) & 16'h1) != 16'h0, so);
        for (int i = 0; i < 7; i++) spi_bit(i[0], so);
        sdi = 1'b1;
        #50;
        sclk = 1'b1;
        csb  = 1'b1;
        #50;
        sclk = 1'b0;
        #100;
        check("race_no_write", 32'(wq.size()), 32'h0);
        check("race_addr", 32'(Addr), 32'h0020);
        check("race_busy", 32'(busy), 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
